// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like memory port between the inst and data requesters with fixed
// data>inst priority, a registered grant and an in-order owner-tag FIFO for responses.
module sram_port_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         resetn,

    input  logic                         inst_req,
    input  logic                         inst_wr,
    input  logic [1:0]                   inst_size,
    input  logic [3:0]                   inst_wstrb,
    input  logic [31:0]                  inst_addr,
    input  logic [31:0]                  inst_wdata,
    output logic                         inst_addr_ok,
    output logic                         inst_data_ok,
    output logic [31:0]                  inst_rdata,

    input  logic                         data_req,
    input  logic                         data_wr,
    input  logic [1:0]                   data_size,
    input  logic [3:0]                   data_wstrb,
    input  logic [31:0]                  data_addr,
    input  logic [31:0]                  data_wdata,
    output logic                         data_addr_ok,
    output logic                         data_data_ok,
    output logic [31:0]                  data_rdata,

    output logic                         mem_req,
    output logic                         mem_wr,
    output logic [1:0]                   mem_size,
    output logic [3:0]                   mem_wstrb,
    output logic [31:0]                  mem_addr,
    output logic [31:0]                  mem_wdata,
    input  logic                         mem_addr_ok,
    input  logic                         mem_data_ok,
    input  logic [31:0]                  mem_rdata,

    output logic [1:0]                   dbg_state,
    output logic [$clog2(DEPTH+1)-1:0]   dbg_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_D = 2'd1,
        GNT_I = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [DEPTH-1:0] tag_q;    // 1 = data owner, 0 = inst owner

    logic push;
    logic pop;
    logic full;
    logic sel_d;
    logic head;

    // Handshake: a request transfers on the cycle where req and addr_ok are both high;
    // req and all its fields stay stable until then. data_ok returns in issue order.
    assign sel_d = (state == GNT_D);
    assign push  = mem_req & mem_addr_ok;
    assign pop   = mem_data_ok & (count != '0);
    assign full  = (count == CW'(DEPTH));
    assign head  = tag_q[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            tag_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!full) begin
                        if (data_req)
                            state <= GNT_D;
                        else if (inst_req)
                            state <= GNT_I;
                    end
                end
                GNT_D, GNT_I: begin
                    if (mem_addr_ok)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (push) begin
                tag_q[wr_ptr] <= sel_d;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (!push && pop)
                count <= count - CW'(1);
        end
    end

    // Request fields follow the inst port whenever data does not hold the grant.
    assign mem_req   = (state != IDLE);
    assign mem_wr    = sel_d ? data_wr    : inst_wr;
    assign mem_size  = sel_d ? data_size  : inst_size;
    assign mem_wstrb = sel_d ? data_wstrb : inst_wstrb;
    assign mem_addr  = sel_d ? data_addr  : inst_addr;
    assign mem_wdata = sel_d ? data_wdata : inst_wdata;

    assign inst_addr_ok = mem_addr_ok & (state == GNT_I);
    assign data_addr_ok = mem_addr_ok & (state == GNT_D);
    assign inst_data_ok = pop & ~head;
    assign data_data_ok = pop & head;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign dbg_state = state;
    assign dbg_count = count;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: grant order, stall, FIFO full, push/pop wrap,
// spurious and post-reset responses.
module tb_sram_port_arbiter;

    logic        clk;
    logic        resetn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;
    logic [1:0]  dbg_count;

    int checks   = 0;
    int failures = 0;
    logic [0:0] exp_q[$];

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GNT_D = 2'd1;
    localparam logic [1:0] S_GNT_I = 2'd2;

    sram_port_arbiter #(.DEPTH(2)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state), .dbg_count(dbg_count)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0;
        inst_wdata = 32'h0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0;
        data_wdata = 32'h0;
        mem_addr_ok = 0; mem_data_ok = 0;
    endtask

    // One accepted handshake for owner tag (1 = data write, 0 = inst read); optionally a
    // response pops in the same cycle. Starts and ends with the FSM in IDLE.
    task automatic xfer(input logic tag, input logic pop_too, input int n);
        logic [0:0] exp_owner;
        logic [31:0] exp_addr;
        inst_req   = !tag;
        inst_addr  = 32'h1c00_1000 + 32'(n * 4);
        data_req   = tag;
        data_wr    = 1'b1;
        data_wstrb = 4'(n + 1);
        data_addr  = 32'h0000_0300 + 32'(n * 4);
        data_wdata = 32'hd000_0000 | 32'(n);
        exp_addr   = tag ? (32'h0000_0300 + 32'(n * 4)) : (32'h1c00_1000 + 32'(n * 4));
        cycle();
        #1;
        check("wrap_mem_addr", mem_addr, exp_addr);
        check("wrap_mem_wr", {31'd0, mem_wr}, {31'd0, tag});
        if (tag) begin
            check("wrap_mem_wdata", mem_wdata, 32'hd000_0000 | 32'(n));
            check("wrap_mem_wstrb", {28'd0, mem_wstrb}, {28'd0, 4'(n + 1)});
        end
        mem_addr_ok = 1'b1;
        mem_data_ok = pop_too;
        mem_rdata   = 32'h0000_5000 + 32'(n);
        #1;
        check("wrap_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, tag ? 32'd1 : 32'd2);
        if (pop_too) begin
            exp_owner = exp_q.pop_front();
            check("wrap_rsp_owner", {30'd0, inst_data_ok, data_data_ok},
                  exp_owner[0] ? 32'd1 : 32'd2);
        end
        exp_q.push_back(tag);
        cycle();
        clear_inputs();
        #1;
        check("wrap_count", {30'd0, dbg_count}, 32'd1);
    endtask

    initial begin : stim
        logic [7:0]  tags;
        logic [0:0]  exp_owner;

        clear_inputs();
        mem_rdata = 32'h0;
        data_addr = 32'h0;
        // reset held with a pending inst request
        resetn    = 1'b0;
        inst_req  = 1'b1;
        inst_addr = 32'h1c00_0000;
        cycle(); cycle();
        #1;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
        check("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        mem_rdata = 32'hcafe_0001;
        #1;
        check("rst_inst_rdata", inst_rdata, 32'hcafe_0001);
        check("rst_data_rdata", data_rdata, 32'hcafe_0001);
        cycle();
        resetn = 1'b1;
        #1;
        check("rel_mem_req_same", {31'd0, mem_req}, 32'd0);
        cycle();
        #1;
        check("rel_mem_req_next", {31'd0, mem_req}, 32'd1);
        check("rel_mem_addr", mem_addr, 32'h1c00_0000);
        mem_addr_ok = 1'b1;
        #1;
        check("rel_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
        check("rel_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
        cycle();
        clear_inputs();
        #1;
        check("rel_idle_gap", {31'd0, mem_req}, 32'd0);
        check("rel_count1", {30'd0, dbg_count}, 32'd1);
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h0000_1234;
        #1;
        check("rel_rsp_inst", {30'd0, inst_data_ok, data_data_ok}, 32'd2);
        check("rel_rsp_rdata", inst_rdata, 32'h0000_1234);
        cycle();
        mem_data_ok = 1'b0;
        #1;
        check("rel_count0", {30'd0, dbg_count}, 32'd0);

        // simultaneous requests: data first, inst after an idle gap
        inst_req  = 1'b1; inst_addr = 32'h1c00_0040;
        data_req  = 1'b1; data_addr = 32'h0000_0100; data_wr = 1'b0;
        cycle();
        #1;
        check("sim_state_d", {30'd0, dbg_state}, {30'd0, S_GNT_D});
        check("sim_addr_d", mem_addr, 32'h0000_0100);
        mem_addr_ok = 1'b1;
        #1;
        check("sim_addr_ok_d", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);
        cycle();
        data_req = 1'b0; mem_addr_ok = 1'b0;
        #1;
        check("sim_idle_gap", {31'd0, mem_req}, 32'd0);
        cycle();
        #1;
        check("sim_addr_i", mem_addr, 32'h1c00_0040);
        mem_addr_ok = 1'b1;
        #1;
        check("sim_addr_ok_i", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
        cycle();
        clear_inputs();
        #1;
        check("sim_count2", {30'd0, dbg_count}, 32'd2);
        mem_data_ok = 1'b1; mem_rdata = 32'h0000_aaaa;
        #1;
        check("sim_rsp1_owner", {30'd0, inst_data_ok, data_data_ok}, 32'd1);
        check("sim_rsp1_rdata", data_rdata, 32'h0000_aaaa);
        cycle();
        mem_rdata = 32'h0000_bbbb;
        #1;
        check("sim_rsp2_owner", {30'd0, inst_data_ok, data_data_ok}, 32'd2);
        check("sim_rsp2_rdata", inst_rdata, 32'h0000_bbbb);
        cycle();
        mem_data_ok = 1'b0;
        #1;
        check("sim_count0", {30'd0, dbg_count}, 32'd0);

        // grant held while mem stalls; data request must not steal it
        inst_req = 1'b1; inst_addr = 32'h1c00_0080;
        cycle();
        data_req = 1'b1; data_addr = 32'h0000_0200;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_addr", mem_addr, 32'h1c00_0080);
            check("stall_state", {30'd0, dbg_state}, {30'd0, S_GNT_I});
            check("stall_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
            cycle();
        end
        mem_addr_ok = 1'b1;
        #1;
        check("stall_accept", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
        cycle();
        inst_req = 1'b0; mem_addr_ok = 1'b0;
        cycle();
        #1;
        check("stall_then_d", mem_addr, 32'h0000_0200);
        mem_addr_ok = 1'b1;
        #1;
        check("stall_d_addr_ok", {31'd0, data_addr_ok}, 32'd1);
        cycle();
        clear_inputs();

        // FIFO full: a third request waits until a response frees a slot
        inst_req = 1'b1; inst_addr = 32'h1c00_00c0;
        cycle();
        #1;
        check("full_count", {30'd0, dbg_count}, 32'd2);
        check("full_no_req_a", {31'd0, mem_req}, 32'd0);
        cycle();
        #1;
        check("full_no_req_b", {31'd0, mem_req}, 32'd0);
        mem_data_ok = 1'b1; mem_rdata = 32'h0000_3333;
        #1;
        check("full_rsp_inst", {30'd0, inst_data_ok, data_data_ok}, 32'd2);
        cycle();
        mem_data_ok = 1'b0;
        #1;
        check("full_count1", {30'd0, dbg_count}, 32'd1);
        check("full_gap", {31'd0, mem_req}, 32'd0);
        cycle();
        #1;
        check("full_granted", {31'd0, mem_req}, 32'd1);
        check("full_granted_addr", mem_addr, 32'h1c00_00c0);
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h0000_4444;
        #1;
        check("pp_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
        check("pp_rsp_data", {30'd0, inst_data_ok, data_data_ok}, 32'd1);
        cycle();
        clear_inputs();
        #1;
        check("pp_count", {30'd0, dbg_count}, 32'd1);
        mem_data_ok = 1'b1;
        #1;
        check("pp_drain_inst", {30'd0, inst_data_ok, data_data_ok}, 32'd2);
        cycle();
        mem_data_ok = 1'b0;

        // push+pop each cycle across several pointer wraps
        tags = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            xfer(tags[i], i != 0, i);
        end
        mem_data_ok = 1'b1;
        exp_owner = exp_q.pop_front();
        #1;
        check("wrap_drain", {30'd0, inst_data_ok, data_data_ok},
              exp_owner[0] ? 32'd1 : 32'd2);
        cycle();
        mem_data_ok = 1'b0;
        #1;
        check("wrap_empty", {30'd0, dbg_count}, 32'd0);

        // spurious response with nothing outstanding
        mem_data_ok = 1'b1;
        #1;
        check("spur_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        cycle();
        mem_data_ok = 1'b0;
        #1;
        check("spur_count", {30'd0, dbg_count}, 32'd0);

        // reset with one transaction outstanding drops its late response
        inst_req = 1'b1; inst_addr = 32'h1c00_0100;
        cycle();
        mem_addr_ok = 1'b1;
        cycle();
        clear_inputs();
        #1;
        check("mid_count1", {30'd0, dbg_count}, 32'd1);
        resetn = 1'b0;
        #1;
        check("mid_rst_count", {30'd0, dbg_count}, 32'd0);
        check("mid_rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        cycle();
        resetn = 1'b1;
        mem_data_ok = 1'b1;
        #1;
        check("mid_late_rsp", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        cycle();
        mem_data_ok = 1'b0;
        #1;
        check("mid_count0", {30'd0, dbg_count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares the single SRAM-like memory port between the fetch-side requester (instruction) and the execute/memory-side requester (data). Requests are granted under fixed priority with a registered grant, and each accepted address handshake is tagged with its owner in an in-order tag FIFO. Returning responses (`data_ok`/`rdata`) are steered back to the owning requester, so the pipeline stages keep their own private-looking SRAM-like interfaces. The block sits between the CPU core and the memory bridge.

## Interface
Parameters:
- `DEPTH`, 2: max outstanding (address-accepted, data-not-returned) transactions; power of two, ≥2.

Ports (`x` = `inst` or `data`; both upstream ports identical):
- `clk`  in  1  clock, all state on rising edge.
- `resetn`  in  1  reset; one clock; reset is asynchronous and active-low.
- `x_req`  in  1  request valid; held stable with all fields until `x_addr_ok`.
- `x_wr`  in  1  1 = write.
- `x_size`  in  2  0/1/2 = byte/half/word.
- `x_wstrb`  in  4  byte enables (write only).
- `x_addr`  in  32  byte address.
- `x_wdata`  in  32  write data.
- `x_addr_ok`  out  1  address handshake accepted this cycle.
- `x_data_ok`  out  1  response for oldest outstanding `x` transaction.
- `x_rdata`  out  32  read data, valid with `x_data_ok`.
- `mem_req`, `mem_wr`, `mem_size`, `mem_wstrb`, `mem_addr`, `mem_wdata`  out  1/1/2/4/32/32  downstream request, same meaning as upstream.
- `mem_addr_ok`  in  1  downstream accepted request.
- `mem_data_ok`  in  1  downstream response (reads and writes), strictly in issue order.
- `mem_rdata`  in  32  downstream read data.

## Operation
- Grant FSM, states IDLE, GNT_D, GNT_I (registered).
  - IDLE: if `count < DEPTH`: `data_req` → GNT_D; else `inst_req` → GNT_I; else stay. If `count == DEPTH`, stay IDLE regardless of requests.
  - GNT_x: `mem_req = 1`; all `mem_*` request fields driven from port x. Stay until `mem_addr_ok`; then → IDLE. Grant never switches while `mem_req` is high.
- `x_addr_ok = mem_addr_ok & (state == GNT_x)`; the other port's `addr_ok` = 0.
- Tag FIFO: `DEPTH` entries of 1 bit (0 = inst, 1 = data), circular read/write pointers (wrap modulo `DEPTH`) plus count 0..`DEPTH`.
  - Push owner tag on `mem_req & mem_addr_ok`.
  - Pop on `mem_data_ok & count != 0`.
  - Push and pop in the same cycle: both pointers advance, count unchanged.
- Response routing: `data_data_ok = mem_data_ok & count != 0 & head == 1`; `inst_data_ok = mem_data_ok & count != 0 & head == 0`. `mem_rdata` is passed combinationally to both `x_rdata`.
- `mem_data_ok` while count == 0 is spurious: ignored, with no pop and no `x_data_ok`.
- Write transactions consume a FIFO slot and return `data_ok` exactly like reads.
- Priority is fixed data > inst.
  - Inst starvation is bounded because the data stage holds at most one request at a time.
  - An IDLE cycle is inserted after every grant.
- Reset (asynchronous, any time, including mid-transaction): state IDLE, pointers 0, count 0. Outstanding downstream responses arriving after reset are dropped by the count == 0 rule.

## Timing
- Reset values: `mem_req` 0; `inst_addr_ok`, `data_addr_ok`, `inst_data_ok`, `data_data_ok` 0; `mem_*` fields follow the inst port (don't-care); `x_rdata` = `mem_rdata`.
- Request latency: `x_req` sampled high in IDLE at edge N → `mem_req` high from cycle N+1.
- `x_addr_ok` is combinational from `mem_addr_ok` (same cycle). The FSM returns to IDLE the following cycle.
- Peak throughput is one address handshake per 2 cycles.
- `x_data_ok` and `x_rdata` are combinational from `mem_data_ok` and `mem_rdata`, with zero added latency.
- A response may pop in the same cycle the FIFO receives a push, including a push of the same transaction's successor.

## Test plan
- Reset: hold `resetn` = 0 with `inst_req` = 1 → all handshake outputs 0 and `mem_req` 0. Release → `mem_req` = 1 one cycle later with `mem_addr` = `inst_addr` (0x1c000000).
- Simultaneous requests: `inst_req` and `data_req` both high in IDLE (data read @0x100) → data granted first. Inst is granted after data's `addr_ok` plus one IDLE cycle. With responses 0xAAAA then 0xBBBB, `data_data_ok` gets 0xAAAA and `inst_data_ok` gets 0xBBBB.
- Stall grant: hold `mem_addr_ok` = 0 for 5 cycles in GNT_I while `data_req` rises → `mem_addr` stays equal to `inst_addr`, no switch, and `data_addr_ok` stays 0.
- FIFO full (`DEPTH` = 2): two accepted transactions with no `data_ok` → a third request sees `mem_req` = 0. Pulse `mem_data_ok` → count 1, and the third is granted next IDLE cycle.
- Simultaneous push/pop: `mem_addr_ok` and `mem_data_ok` in the same cycle with count 1 → count stays 1 and the tag order is preserved across pointer wrap over 8 transactions.
- Spurious `mem_data_ok` with count 0 → no `x_data_ok` and count stays 0. Reset asserted mid-outstanding → the next `mem_data_ok` is ignored.
